// File: rtl/coin_pkg.sv
// Shared types and default parameters for the coin acceptor front end.
package coin_pkg;

  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_t;

  typedef logic [1:0] out_state_t;
  localparam out_state_t IDLE  = 2'd0;
  localparam out_state_t PULSE = 2'd1;
  localparam out_state_t GAP   = 2'd2;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_JAM_CYCLES      = 64;
  localparam int DEF_GAP_CYCLES      = 2;
  localparam int DEF_FIFO_DEPTH      = 4;

endpackage

// File: rtl/coin_debounce.sv
// One coin chute: synchroniser, debounce, rising-edge event and sticky jam detection.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int JAM_CYCLES      = DEF_JAM_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sense_raw,
  output logic evt,
  output logic jam
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int JAM_W = $clog2(JAM_CYCLES) + 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             evt_q, evt_d;
  logic             jam_q, jam_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [JAM_W-1:0] jam_cnt_q, jam_cnt_d;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else db_cnt_d = db_cnt_q + DB_W'(1);
    end

    jam_cnt_d = '0;
    if (level_q) begin
      jam_cnt_d = jam_cnt_q;
      if (jam_cnt_q != JAM_W'(JAM_CYCLES)) jam_cnt_d = jam_cnt_q + JAM_W'(1);
    end
    jam_d = jam_q | (jam_cnt_q == JAM_W'(JAM_CYCLES));

    // A jammed chute drops its events silently; the coin that caused the jam was already sent
    evt_d = level_q & ~level_dly_q & ~jam_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      db_cnt_q    <= '0;
      jam_cnt_q   <= '0;
      jam_q       <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      sync1_q     <= sense_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      db_cnt_q    <= db_cnt_d;
      jam_cnt_q   <= jam_cnt_d;
      jam_q       <= jam_d;
      evt_q       <= evt_d;
    end
  end

  assign evt = evt_q;
  assign jam = jam_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: arbitrates chute events into a small FIFO and paces
// clean single-cycle coin pulses for the downstream vending FSM.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int JAM_CYCLES      = DEF_JAM_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic sense_5_raw,
  input  logic sense_10_raw,
  output logic coin_5,
  output logic coin_10,
  output logic coin_reject,
  output logic coin_pending,
  output logic jam_5,
  output logic jam_10
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  logic evt_5, evt_10;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_db_5 (
    .clk(clk), .reset(reset), .sense_raw(sense_5_raw), .evt(evt_5), .jam(jam_5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_db_10 (
    .clk(clk), .reset(reset), .sense_raw(sense_10_raw), .evt(evt_10), .jam(jam_10)
  );

  coin_t            fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  out_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             coin_5_q, coin_5_d, coin_10_q, coin_10_d;
  logic             reject_q, reject_d, pending_q, pending_d;
  logic             pop, push, single, full;
  coin_t            push_type;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    coin_5_d  = 1'b0;
    coin_10_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          state_d   = PULSE;
          coin_5_d  = (fifo_mem_q[rd_ptr_q] == COIN_5);
          coin_10_d = (fifo_mem_q[rd_ptr_q] == COIN_10);
        end
      end
      PULSE: begin
        state_d   = GAP;
        gap_cnt_d = GAP_W'(GAP_CYCLES);
      end
      GAP: begin
        // The IDLE pop cycle is the last idle cycle, so leave GAP one count early
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_d <= GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    single    = evt_5 ^ evt_10;
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    push      = single & (~full | pop);
    push_type = evt_10 ? COIN_10 : COIN_5;
    reject_d  = (evt_5 & evt_10) | (single & full & ~pop);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    pending_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_type;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      coin_5_q  <= 1'b0;
      coin_10_q <= 1'b0;
      reject_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      coin_5_q  <= coin_5_d;
      coin_10_q <= coin_10_d;
      reject_q  <= reject_d;
      pending_q <= pending_d;
    end
  end

  assign coin_5       = coin_5_q;
  assign coin_10      = coin_10_q;
  assign coin_reject  = reject_q;
  assign coin_pending = pending_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: a default instance and a long-gap instance.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_s5 = 1'b0, a_s10 = 1'b0, b_s5 = 1'b0, b_s10 = 1'b0;
  logic a_c5, a_c10, a_rej, a_pend, a_j5, a_j10;
  logic b_c5, b_c10, b_rej, b_pend, b_j5, b_j10;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   q_a5[$], q_a10[$], q_arej[$], q_b5[$], q_b10[$], q_brej[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(64), .GAP_CYCLES(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .sense_5_raw(a_s5), .sense_10_raw(a_s10),
    .coin_5(a_c5), .coin_10(a_c10), .coin_reject(a_rej), .coin_pending(a_pend),
    .jam_5(a_j5), .jam_10(a_j10)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(64), .GAP_CYCLES(40), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .sense_5_raw(b_s5), .sense_10_raw(b_s10),
    .coin_5(b_c5), .coin_10(b_c10), .coin_reject(b_rej), .coin_pending(b_pend),
    .jam_5(b_j5), .jam_10(b_j10)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({a_c5, a_c10, a_rej, a_pend, a_j5, a_j10, b_c5, b_c10, b_rej, b_pend, b_j5, b_j10} !== 12'b0) begin
      errors++;
      $display("FAIL reset_held: outputs a=%b%b%b%b%b%b b=%b%b%b%b%b%b, required all 0",
               a_c5, a_c10, a_rej, a_pend, a_j5, a_j10, b_c5, b_c10, b_rej, b_pend, b_j5, b_j10);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if ({a_c5, a_c10, a_rej, a_pend, a_j5, a_j10, b_c5, b_c10, b_rej, b_pend, b_j5, b_j10} !== 12'b0) begin
      errors++;
      $display("FAIL reset_release: outputs not all 0 on first cycle after release");
    end
    tick(10);
  endtask

  task automatic test_single5;
    int e0;
    a_s5 = 1'b1;
    e0 = cyc + 1;
    q_a5.push_back(e0 + 8);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i >= 6 && i <= 8) begin
        checks++;
        if (a_pend !== (i == 7)) begin
          errors++;
          $display("FAIL single5_pending: edge %0d got %b, required %b", i, a_pend, (i == 7));
        end
      end
      if (i == 19) a_s5 = 1'b0;
    end
    tick(20);
    checks++;
    if (q_a5.size() + q_a10.size() + q_arej.size() != 0) begin
      errors++;
      $display("FAIL single5_drain: %0d expected pulses missing, required 0", q_a5.size() + q_a10.size() + q_arej.size());
    end
  endtask

  task automatic test_bounce10;
    int e0;
    for (int g = 0; g < 10; g++) begin
      a_s10 = 1'b1;
      tick(1 + g % 3);
      a_s10 = 1'b0;
      tick(2);
    end
    a_s10 = 1'b1;
    e0 = cyc + 1;
    q_a10.push_back(e0 + 8);
    tick(20);
    a_s10 = 1'b0;
    tick(20);
    checks++;
    if (q_a5.size() + q_a10.size() + q_arej.size() != 0) begin
      errors++;
      $display("FAIL bounce10_drain: %0d expected pulses missing, required 0", q_a5.size() + q_a10.size() + q_arej.size());
    end
  endtask

  task automatic test_simultaneous;
    int e0;
    a_s5 = 1'b1;
    a_s10 = 1'b1;
    e0 = cyc + 1;
    q_arej.push_back(e0 + 7);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i == 7 || i == 8) begin
        checks++;
        if (a_pend !== 1'b0) begin
          errors++;
          $display("FAIL simul_pending: edge %0d got %b, required 0", i, a_pend);
        end
      end
    end
    a_s5 = 1'b0;
    a_s10 = 1'b0;
    tick(20);
    checks++;
    if (q_a5.size() + q_a10.size() + q_arej.size() != 0) begin
      errors++;
      $display("FAIL simul_drain: %0d expected pulses missing, required 0", q_a5.size() + q_a10.size() + q_arej.size());
    end
  endtask

  task automatic test_back_to_back;
    int e0;
    a_s5 = 1'b1;
    e0 = cyc + 1;
    q_a5.push_back(e0 + 8);
    q_a10.push_back(e0 + 11);
    tick(1);
    a_s10 = 1'b1;
    tick(5);
    a_s5 = 1'b0;
    tick(1);
    a_s10 = 1'b0;
    tick(20);
    checks++;
    if (q_a5.size() + q_a10.size() + q_arej.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d expected pulses missing, required 0", q_a5.size() + q_a10.size() + q_arej.size());
    end
  endtask

  task automatic test_jam;
    int e0;
    a_s5 = 1'b1;
    e0 = cyc + 1;
    q_a5.push_back(e0 + 8);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (i == 69 || i == 70) begin
        checks++;
        if (a_j5 !== (i == 70)) begin
          errors++;
          $display("FAIL jam5_set: edge %0d got %b, required %b", i, a_j5, (i == 70));
        end
      end
      if (i == 99) a_s5 = 1'b0;
    end
    tick(10);
    a_s5 = 1'b1;
    tick(10);
    a_s5 = 1'b0;
    tick(20);
    checks++;
    if (a_j5 !== 1'b1 || q_a5.size() + q_arej.size() != 0) begin
      errors++;
      $display("FAIL jam5_sticky: jam_5=%b outstanding=%0d, required 1 and 0", a_j5, q_a5.size() + q_arej.size());
    end
    a_s10 = 1'b1;
    e0 = cyc + 1;
    q_a10.push_back(e0 + 8);
    tick(10);
    a_s10 = 1'b0;
    tick(20);
    checks++;
    if (a_j10 !== 1'b0 || q_a10.size() != 0) begin
      errors++;
      $display("FAIL jam10_channel: jam_10=%b outstanding=%0d, required 0 and 0", a_j10, q_a10.size());
    end
  endtask

  task automatic test_overflow;
    int e0;
    e0 = cyc + 1;
    for (int k = 0; k < 5; k++) q_b10.push_back(e0 + 8 + 41 * k);
    q_brej.push_back(e0 + 47);
    for (int k = 0; k < 6; k++) begin
      b_s10 = 1'b1;
      tick(4);
      b_s10 = 1'b0;
      tick(4);
    end
    checks++;
    if (b_pend !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pending: got %b with queue full, required 1", b_pend);
    end
    tick(200);
    checks++;
    if (b_pend !== 1'b0 || q_b10.size() + q_brej.size() != 0) begin
      errors++;
      $display("FAIL overflow_drain: pending=%b outstanding=%0d, required 0 and 0", b_pend, q_b10.size() + q_brej.size());
    end
  endtask

  task automatic test_reset_mid;
    int e0;
    e0 = cyc + 1;
    q_b5.push_back(e0 + 8);
    q_b5.push_back(e0 + 49);
    for (int k = 0; k < 4; k++) begin
      b_s5 = 1'b1;
      tick(4);
      b_s5 = 1'b0;
      tick(4);
    end
    tick(17);
    checks++;
    if (b_pend !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending_before: got %b, required 1", b_pend);
    end
    tick(1);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({b_c5, b_c10, b_rej, b_pend} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_drop: c5=%b c10=%b rej=%b pend=%b, required all 0", b_c5, b_c10, b_rej, b_pend);
    end
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++;
    if ({b_c5, b_c10, b_rej, b_pend} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_release: outputs not all 0 on first cycle after release");
    end
    tick(150);
    checks++;
    if (b_pend !== 1'b0 || q_b5.size() + q_b10.size() + q_brej.size() != 0) begin
      errors++;
      $display("FAIL rstmid_after: pending=%b outstanding=%0d, required 0 and 0", b_pend, q_b5.size() + q_b10.size() + q_brej.size());
    end
  endtask

  initial begin
    fork
      begin : monitor
        int ev;
        forever begin
          @(negedge clk);
          if (a_c5 || a_c10) begin
            checks++;
            if (a_c5 && a_c10) begin errors++; $display("FAIL a_exclusive: both coin pulses high at edge %0d", cyc); end
          end
          if (b_c5 || b_c10) begin
            checks++;
            if (b_c5 && b_c10) begin errors++; $display("FAIL b_exclusive: both coin pulses high at edge %0d", cyc); end
          end
          if (a_c5) begin
            checks++;
            if (q_a5.size() == 0) begin errors++; $display("FAIL a_coin_5: pulse at edge %0d, required none", cyc); end
            else begin ev = q_a5.pop_front(); if (cyc != ev) begin errors++; $display("FAIL a_coin_5: pulse at edge %0d, required %0d", cyc, ev); end end
          end
          if (a_c10) begin
            checks++;
            if (q_a10.size() == 0) begin errors++; $display("FAIL a_coin_10: pulse at edge %0d, required none", cyc); end
            else begin ev = q_a10.pop_front(); if (cyc != ev) begin errors++; $display("FAIL a_coin_10: pulse at edge %0d, required %0d", cyc, ev); end end
          end
          if (a_rej) begin
            checks++;
            if (q_arej.size() == 0) begin errors++; $display("FAIL a_reject: pulse at edge %0d, required none", cyc); end
            else begin ev = q_arej.pop_front(); if (cyc != ev) begin errors++; $display("FAIL a_reject: pulse at edge %0d, required %0d", cyc, ev); end end
          end
          if (b_c5) begin
            checks++;
            if (q_b5.size() == 0) begin errors++; $display("FAIL b_coin_5: pulse at edge %0d, required none", cyc); end
            else begin ev = q_b5.pop_front(); if (cyc != ev) begin errors++; $display("FAIL b_coin_5: pulse at edge %0d, required %0d", cyc, ev); end end
          end
          if (b_c10) begin
            checks++;
            if (q_b10.size() == 0) begin errors++; $display("FAIL b_coin_10: pulse at edge %0d, required none", cyc); end
            else begin ev = q_b10.pop_front(); if (cyc != ev) begin errors++; $display("FAIL b_coin_10: pulse at edge %0d, required %0d", cyc, ev); end end
          end
          if (b_rej) begin
            checks++;
            if (q_brej.size() == 0) begin errors++; $display("FAIL b_reject: pulse at edge %0d, required none", cyc); end
            else begin ev = q_brej.pop_front(); if (cyc != ev) begin errors++; $display("FAIL b_reject: pulse at edge %0d, required %0d", cyc, ev); end end
          end
        end
      end
    join_none

    test_reset();
    test_single5();
    test_bounce10();
    test_simultaneous();
    test_back_to_back();
    test_jam();
    test_overflow();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
